fir_seq_mac_ctrl: RTL

//  Parametrised, time-multiplexed FIR engine and controller: TAPS-deep delay line, coefficient bank,
//  one multiplier and an accumulator sequenced by an FSM, one tap per clock.

---
 rtl/fir_seq_mac_ctrl_if.sv | 23 ++
 rtl/fir_seq_mac_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fir_seq_mac_ctrl_if.sv
// Sample/result handshake bundle for the time-multiplexed FIR engine.
// The master side is the sample source and result consumer. The slave side is the engine.
interface fir_seq_mac_ctrl_if #(
    parameter int DW = 8
);
    logic [DW-1:0] x_in;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] y;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    modport master (
        output x_in, in_valid, out_ready,
        input  in_ready, y, out_valid, busy
    );

    modport slave (
        input  x_in, in_valid, out_ready,
        output in_ready, y, out_valid, busy
    );
endinterface

// File: rtl/fir_seq_mac_ctrl.sv
// Time-multiplexed FIR engine: TAPS-deep delay line, coefficient bank, one multiplier
// and an accumulator. One tap is processed per clock, in the order IDLE -> MAC -> DONE.
// Optional feature macro: FIR_COEF_LOAD_EN adds a run-time coefficient write port.
// The write port is honoured only in IDLE.
// COEF_INIT is packed with c[0] in the least significant CW bits.
// The default value is the tap set 3,2,3,4,2,4,5,3 for c[0]..c[7].
module fir_seq_mac_ctrl #(
    parameter int DW        = 8,
    parameter int CW        = 8,
    parameter int TAPS      = 8,
    parameter int OUT_SHIFT = 0,
    parameter logic [TAPS*CW-1:0] COEF_INIT =
        {8'd3, 8'd5, 8'd4, 8'd2, 8'd4, 8'd3, 8'd2, 8'd3}
)(
    input  logic                    clk,
    input  logic                    reset,
`ifdef FIR_COEF_LOAD_EN
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [CW-1:0]           coef_wdata,
`endif
    fir_seq_mac_ctrl_if.slave       bus
);

    localparam int KW = $clog2(TAPS);
    localparam int PW = DW + CW;
    localparam int AW = DW + CW + $clog2(TAPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic          accept_s;
    logic          last_tap_s;

    logic [DW-1:0] x_r    [TAPS];
    logic [CW-1:0] coef_s [TAPS];
    logic [KW-1:0] k_r;
    logic [AW-1:0] acc_r;
    logic [PW-1:0] prod_s;
    logic [AW-1:0] acc_next_s;
    logic [AW-1:0] acc_shift_s;

    logic [DW-1:0] y_r;
    logic          out_valid_r;
    logic          in_ready_r;
    logic          busy_r;

    assign last_tap_s    = (k_r == KW'(TAPS - 1));

    assign bus.y         = y_r;
    assign bus.out_valid = out_valid_r;
    assign bus.in_ready  = in_ready_r;
    assign bus.busy      = busy_r;

`ifdef FIR_COEF_LOAD_EN
    logic [CW-1:0] coef_r [TAPS];
    logic [31:0]   coef_addr_ext_s;
    logic          coef_wr_ok_s;

    // Writes land only while idle, so a running sum never sees a coefficient change.
    assign coef_addr_ext_s = 32'(coef_addr);
    assign coef_wr_ok_s    = (state_r == IDLE) && coef_we && (coef_addr_ext_s < 32'(TAPS));

    // Coefficient bank: reloaded from COEF_INIT on reset, written from the load port when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                coef_r[i] <= COEF_INIT[i*CW +: CW];
            end
        end else if (coef_wr_ok_s) begin
            coef_r[coef_addr] <= coef_wdata;
        end
    end

    // Present the writable bank to the multiplier.
    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            coef_s[i] = coef_r[i];
        end
    end
`else
    // Fixed coefficient set, unpacked from the reset constant.
    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            coef_s[i] = COEF_INIT[i*CW +: CW];
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode: accept a sample in IDLE, step taps in MAC, wait for the consumer in DONE.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = MAC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MAC: begin
                if (last_tap_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = MAC;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Multiply-accumulate for the current tap. The accumulator is sized so it cannot wrap.
    always_comb begin
        prod_s      = PW'(x_r[k_r]) * PW'(coef_s[k_r]);
        acc_next_s  = acc_r + AW'(prod_s);
        acc_shift_s = acc_next_s >> OUT_SHIFT;
    end

    // Delay line, accumulator and tap index.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                x_r[i] <= {DW{1'b0}};
            end
            acc_r <= {AW{1'b0}};
            k_r   <= {KW{1'b0}};
        end else if (accept_s) begin
            x_r[0] <= bus.x_in;
            for (int i = 1; i < TAPS; i++) begin
                x_r[i] <= x_r[i-1];
            end
            acc_r <= {AW{1'b0}};
            k_r   <= {KW{1'b0}};
        end else if (state_r == MAC) begin
            acc_r <= acc_next_s;
            if (last_tap_s) begin
                k_r <= {KW{1'b0}};
            end else begin
                k_r <= k_r + KW'(1);
            end
        end
    end

    // Registered handshake outputs. y is captured with the final tap and held until the next result.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_r         <= {DW{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= (state_next_s == IDLE);
            busy_r      <= (state_next_s != IDLE);
            out_valid_r <= (state_next_s == DONE);
            if ((state_r == MAC) && last_tap_s) begin
                y_r <= acc_shift_s[DW-1:0];
            end
        end
    end

endmodule
